// File: rtl/dcache_resp_pkg.sv
// rtl/dcache_resp_pkg.sv - shared width codes, FSM states and strobe helper for the data-cache responder
package dcache_resp_pkg;

    localparam logic [1:0] MW_BYTE = 2'b00;
    localparam logic [1:0] MW_HALF = 2'b01;
    localparam logic [1:0] MW_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        REFILL = 2'b01,
        WRITE  = 2'b10,
        RESP   = 2'b11
    } dc_state_t;

    // Strobe pattern for lane 0; the code 2'b11 behaves as a full word.
    function automatic logic [3:0] width_mask(input logic [1:0] width);
        case (width)
            MW_BYTE: width_mask = 4'b0001;
            MW_HALF: width_mask = 4'b0011;
            default: width_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/dcache_ld_align.sv
// rtl/dcache_ld_align.sv - load extract/extend and store lane shift/strobe generation (combinational)
module dcache_ld_align
    import dcache_resp_pkg::*;
(
    input  logic [31:0] ld_word,
    input  logic [1:0]  offset,
    input  logic [1:0]  width,
    input  logic        rdtype,
    input  logic [31:0] st_data,
    output logic [31:0] ld_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb
);

    logic [1:0]  lane;
    logic [31:0] ld_shift;
    logic [31:0] st_masked;

    // Halves ignore addr[0]; words ignore the whole offset.
    assign lane     = (width == MW_BYTE) ? offset :
                      (width == MW_HALF) ? {offset[1], 1'b0} : 2'b00;
    assign ld_shift = ld_word >> {lane, 3'b000};

    always_comb begin
        ld_data   = ld_word;
        st_masked = st_data;
        case (width)
            MW_BYTE: begin
                ld_data   = {{24{~rdtype & ld_shift[7]}}, ld_shift[7:0]};
                st_masked = {24'h0, st_data[7:0]};
            end
            MW_HALF: begin
                ld_data   = {{16{~rdtype & ld_shift[15]}}, ld_shift[15:0]};
                st_masked = {16'h0, st_data[15:0]};
            end
            default: begin
                ld_data   = ld_word;
                st_masked = st_data;
            end
        endcase
    end

    assign st_wdata = st_masked << {lane, 3'b000};
    assign st_wstrb = width_mask(width) << lane;

endmodule

// File: rtl/dcache_resp.sv
// rtl/dcache_resp.sv - direct-mapped write-through data cache responder; DCACHE_PERF_CNT_EN adds hit/miss counters
module dcache_resp
    import dcache_resp_pkg::*;
#(
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_req_Dcache_i,
    input  logic        ex_mem_rw_i,
    input  logic [31:0] ex_mem_addr_i,
    input  logic [1:0]  ex_mem_wrwidth_i,
    input  logic [31:0] ex_mem_wr_data_i,
    input  logic        ex_mem_rdtype_i,
    output logic [31:0] dc_rd_data_o,
    output logic        dc_ready_o,
    output logic        dc_stall_req_o,
`ifdef DCACHE_PERF_CNT_EN
    output logic [31:0] dc_hit_cnt_o,
    output logic [31:0] dc_miss_cnt_o,
`endif
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);

    localparam int WB = $clog2(LINE_WORDS);
    localparam int IB = $clog2(SETS);
    localparam int TB = 32 - 2 - WB - IB;

    dc_state_t       state_q;
    logic [SETS-1:0] valid_q;
    logic [TB-1:0]   tag_q  [SETS];
    logic [31:0]     data_q [SETS][LINE_WORDS];
    logic [WB-1:0]   refill_cnt_q;
    logic [31:0]     rq_addr_q;
    logic [1:0]      rq_width_q;
    logic            rq_rdtype_q;

    logic            dc_ready_q;
    logic [31:0]     rd_data_q;
    logic            mem_req_q;
    logic            mem_we_q;
    logic [31:0]     mem_addr_q;
    logic [31:0]     mem_wdata_q;
    logic [3:0]      mem_wstrb_q;

    logic [IB-1:0]   lk_idx;
    logic [WB-1:0]   lk_word;
    logic [TB-1:0]   lk_tag;
    logic            lk_hit;
    logic            accept;
    logic            in_refill;
    logic            bus_ack;
    logic            last_ack;
    logic [IB-1:0]   rq_idx;
    logic [31:0]     al_addr;
    logic [1:0]      al_width;
    logic            al_rdtype;
    logic [IB-1:0]   al_idx;
    logic [WB-1:0]   al_word;
    logic [31:0]     al_word_data;
    logic [31:0]     ld_data;
    logic [31:0]     st_wdata;
    logic [3:0]      st_wstrb;

    assign lk_idx  = ex_mem_addr_i[2+WB +: IB];
    assign lk_word = ex_mem_addr_i[2 +: WB];
    assign lk_tag  = ex_mem_addr_i[31 -: TB];
    assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    // A request still high in the ready cycle belongs to the access just retired.
    assign accept    = (state_q == IDLE) && ex_req_Dcache_i && !dc_ready_q;
    assign in_refill = (state_q == REFILL);
    assign bus_ack   = mem_ack_i && mem_req_q;
    assign last_ack  = in_refill && bus_ack && (refill_cnt_q == WB'(LINE_WORDS - 1));
    assign rq_idx    = rq_addr_q[2+WB +: IB];

    // One aligner serves both the hit path (live request) and the refill response (latched request).
    assign al_addr      = in_refill ? rq_addr_q   : ex_mem_addr_i;
    assign al_width     = in_refill ? rq_width_q  : ex_mem_wrwidth_i;
    assign al_rdtype    = in_refill ? rq_rdtype_q : ex_mem_rdtype_i;
    assign al_idx       = al_addr[2+WB +: IB];
    assign al_word      = al_addr[2 +: WB];
    assign al_word_data = (in_refill && (al_word == refill_cnt_q)) ? mem_rdata_i
                                                                    : data_q[al_idx][al_word];

    dcache_ld_align u_align (
        .ld_word  (al_word_data),
        .offset   (al_addr[1:0]),
        .width    (al_width),
        .rdtype   (al_rdtype),
        .st_data  (ex_mem_wr_data_i),
        .ld_data  (ld_data),
        .st_wdata (st_wdata),
        .st_wstrb (st_wstrb)
    );

    always_comb begin
        dc_stall_req_o = 1'b0;
        case (state_q)
            IDLE:          dc_stall_req_o = accept && (ex_mem_rw_i || !lk_hit);
            REFILL, WRITE: dc_stall_req_o = 1'b1;
            default:       dc_stall_req_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept && ex_mem_rw_i && lk_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (st_wstrb[b]) data_q[lk_idx][lk_word][8*b +: 8] <= st_wdata[8*b +: 8];
            end
        end
        if (in_refill && bus_ack) begin
            data_q[rq_idx][refill_cnt_q] <= mem_rdata_i;
            if (last_ack) tag_q[rq_idx] <= rq_addr_q[31 -: TB];
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= 32'h0;
            miss_cnt_q <= 32'h0;
        end else if (accept && !ex_mem_rw_i) begin
            if (lk_hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
            else        miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign dc_hit_cnt_o  = hit_cnt_q;
    assign dc_miss_cnt_o = miss_cnt_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            refill_cnt_q <= '0;
            rq_addr_q    <= 32'h0;
            rq_width_q   <= 2'b00;
            rq_rdtype_q  <= 1'b0;
            dc_ready_q   <= 1'b0;
            rd_data_q    <= 32'h0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            mem_wstrb_q  <= 4'h0;
        end else begin
            dc_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        rq_addr_q   <= ex_mem_addr_i;
                        rq_width_q  <= ex_mem_wrwidth_i;
                        rq_rdtype_q <= ex_mem_rdtype_i;
                        if (ex_mem_rw_i) begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= {ex_mem_addr_i[31:2], 2'b00};
                            mem_wdata_q <= st_wdata;
                            mem_wstrb_q <= st_wstrb;
                            state_q     <= WRITE;
                        end else if (lk_hit) begin
                            rd_data_q  <= ld_data;
                            dc_ready_q <= 1'b1;
                        end else begin
                            // Line is rewritten word by word, so it must not look valid meanwhile.
                            valid_q[lk_idx] <= 1'b0;
                            refill_cnt_q    <= '0;
                            mem_req_q       <= 1'b1;
                            mem_we_q        <= 1'b0;
                            mem_addr_q      <= {ex_mem_addr_i[31:2+WB], {(2+WB){1'b0}}};
                            mem_wdata_q     <= 32'h0;
                            mem_wstrb_q     <= 4'h0;
                            state_q         <= REFILL;
                        end
                    end
                end
                REFILL: begin
                    if (last_ack) begin
                        mem_req_q       <= 1'b0;
                        valid_q[rq_idx] <= 1'b1;
                        rd_data_q       <= ld_data;
                        dc_ready_q      <= 1'b1;
                        state_q         <= RESP;
                    end else if (bus_ack) begin
                        refill_cnt_q <= refill_cnt_q + 1'b1;
                        mem_addr_q   <= mem_addr_q + 32'd4;
                    end
                end
                WRITE: begin
                    if (bus_ack) begin
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_wstrb_q <= 4'h0;
                        dc_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dc_ready_o   = dc_ready_q;
    assign dc_rd_data_o = rd_data_q;
    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign mem_wstrb_o  = mem_wstrb_q;

endmodule
